voter_auth: RTL and testbench
=============================

VOTER_AUTH -- requirements
Module: voter_auth

Interface
REQ-001 SHALL have parameter ID_W, default 6, width of voter ID.
REQ-002 SHALL have parameter NUM_IDS, default 40, number of registered IDs (1..2**ID_W); IDs >= NUM_IDS are out of range.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, session timeout in cycles (>=1; used only with IDCHK_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  authentication request.
REQ-007 SHALL have port req_id  input  ID_W  ID to authenticate.
REQ-008 SHALL have port req_ready  output  1  request acceptable; high only in IDLE.
REQ-009 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-010 SHALL have port resp_code  output  2  00 granted, 01 already voted, 10 out of range; 11 reserved, never driven.
REQ-011 SHALL have port commit  input  1  vote cast; marks session ID as voted.
REQ-012 SHALL have port abort  input  1  cancel session without marking.
REQ-013 SHALL have port session_active  output  1  high in SESSION.
REQ-014 SHALL have port session_id  output  ID_W  ID held by the open session.
REQ-015 SHALL have port voted_count  output  $clog2(NUM_IDS+1)  number of IDs marked voted.
REQ-016 SHALL have port all_voted  output  1  high when voted_count == NUM_IDS.
REQ-017 SHALL have port timeout  output  1  one-cycle pulse on session expiry.

Function
REQ-018 SHALL hold one voted flag per ID (NUM_IDS bits) and use a two-state FSM: IDLE, SESSION.
REQ-019 SHALL accept a request when req_valid && req_ready, registering req_id; resp_valid/resp_code SHALL appear exactly one cycle later for one cycle.
REQ-020 SHALL return out of range (10) for IDs >= NUM_IDS, else already voted (01) if the flag is set, else granted (00); the range check takes precedence.
REQ-021 SHALL, on granted, enter SESSION in the same cycle resp_valid rises, with session_id = accepted ID; on any other code the FSM SHALL stay in IDLE.
REQ-022 SHALL ignore commit and abort outside SESSION.
REQ-023 SHALL, on commit in SESSION, set the session ID's flag, increment voted_count, and return to IDLE on the next cycle.
REQ-024 SHALL, on abort in SESSION, return to IDLE without changing flags or count.
REQ-025 SHALL give commit priority when commit and abort are asserted in the same cycle.
REQ-026 SHALL keep req_ready low in SESSION; requests presented then SHALL be neither accepted nor answered.
REQ-027 SHALL never let voted_count exceed NUM_IDS or mark a flag twice; re-entry of a voted ID is refused by REQ-020.
REQ-028 SHALL hold session_id at its last value in IDLE.

Reset
REQ-029 SHALL, on reset, clear all flags, voted_count = 0, FSM = IDLE, req_ready = 1, resp_valid = 0, resp_code = 00, session_active = 0, session_id = 0, all_voted = 0, timeout = 0.
REQ-030 SHALL, on reset mid-session, drop the session without marking; reset overrides all inputs in that cycle.

Configuration
REQ-031 SHALL, with IDCHK_TIMEOUT_EN defined, count cycles in SESSION from 0 and, if no commit/abort arrives by count TIMEOUT_CYC, return to IDLE unmarked and pulse timeout for one cycle; commit in the expiry cycle SHALL win.
REQ-032 SHALL, without IDCHK_TIMEOUT_EN, hold SESSION indefinitely and tie timeout to 0, with no timeout counter.

Verification
REQ-033 SHALL cover: reset, request ID 5 -> resp_code 00 next cycle, session_active=1, session_id=5; commit -> voted_count=1.
REQ-034 SHALL cover: ID 5 requested again after commit -> resp_code 01, session_active stays 0.
REQ-035 SHALL cover: ID 45 with NUM_IDS=40 -> resp_code 10; ID 39 -> 00.
REQ-036 SHALL cover: grant ID 7, commit+abort together -> flag 7 set, count increments; grant ID 8, abort -> ID 8 later granted again.
REQ-037 SHALL cover: mark all 40 IDs -> all_voted=1, voted_count=40; reset mid-session -> all flags and count cleared.
REQ-038 SHALL cover, with IDCHK_TIMEOUT_EN and TIMEOUT_CYC=10: grant ID 3, idle 10 cycles -> timeout pulse, IDLE, ID 3 still grantable.

Source files
------------

// File: rtl/voter_auth_if.sv
// rtl/voter_auth_if.sv - request/response and session-control handshake bundle for voter_auth
interface voter_auth_if #(
    parameter int ID_W = 6
) ();
    logic            req_valid;
    logic [ID_W-1:0] req_id;
    logic            req_ready;
    logic            resp_valid;
    logic [1:0]      resp_code;
    logic            commit;
    logic            abort;

    modport master (
        output req_valid, req_id, commit, abort,
        input  req_ready, resp_valid, resp_code
    );

    modport slave (
        input  req_valid, req_id, commit, abort,
        output req_ready, resp_valid, resp_code
    );
endinterface

// File: rtl/voter_auth.sv
// rtl/voter_auth.sv - voter ID authentication with one-vote-per-ID sessions
// Optional session expiry enabled by defining IDCHK_TIMEOUT_EN.
module voter_auth #(
    parameter int ID_W        = 6,
    parameter int NUM_IDS     = 40,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    voter_auth_if.slave                  bus,
    output logic                         session_active,
    output logic [ID_W-1:0]              session_id,
    output logic [$clog2(NUM_IDS+1)-1:0] voted_count,
    output logic                         all_voted,
    output logic                         timeout
);
    localparam int              CNT_W     = $clog2(NUM_IDS + 1);
    localparam logic [ID_W:0]   NUM_IDS_W = NUM_IDS[ID_W:0];
    localparam logic [CNT_W-1:0] NUM_IDS_C = NUM_IDS[CNT_W-1:0];

    typedef enum logic {IDLE, SESSION} state_t;

    state_t             state_q, state_d;
    logic [NUM_IDS-1:0] flags;
    logic [NUM_IDS-1:0] sess_mask;
    logic               in_range, id_voted, sess_flag;
    logic [1:0]         code_d;
    logic               accept, grant, do_commit, do_abort, expire;
    logic               timer_done;

    // Lookups walk only the registered range so out-of-range IDs never index the flag vector.
    always_comb begin
        id_voted  = 1'b0;
        sess_mask = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (bus.req_id == ID_W'(i))
                id_voted = flags[i];
            sess_mask[i] = (session_id == ID_W'(i));
        end
    end

    assign in_range  = ({1'b0, bus.req_id} < NUM_IDS_W);
    assign sess_flag = |(flags & sess_mask);
    assign code_d    = !in_range ? 2'b10 : (id_voted ? 2'b01 : 2'b00);

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        grant     = 1'b0;
        do_commit = 1'b0;
        do_abort  = 1'b0;
        expire    = 1'b0;
        case (state_q)
            IDLE: begin
                accept = bus.req_valid;
                if (accept && code_d == 2'b00) begin
                    grant   = 1'b1;
                    state_d = SESSION;
                end
            end
            SESSION: begin
                if (bus.commit) begin
                    do_commit = 1'b1;
                    state_d   = IDLE;
                end else if (bus.abort) begin
                    do_abort = 1'b1;
                    state_d  = IDLE;
                end else if (timer_done) begin
                    expire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.resp_valid <= 1'b0;
            bus.resp_code  <= 2'b00;
            session_id     <= '0;
            flags          <= '0;
            voted_count    <= '0;
        end else begin
            bus.resp_valid <= accept;
            if (accept)
                bus.resp_code <= code_d;
            if (grant)
                session_id <= bus.req_id;
            // A set flag blocks re-grant, so this guard only protects the count invariant.
            if (do_commit && !sess_flag) begin
                flags       <= flags | sess_mask;
                voted_count <= voted_count + CNT_W'(1);
            end
        end
    end

`ifdef IDCHK_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] timer_q;

    assign timer_done = (timer_q == TMR_W'(TIMEOUT_CYC));

    // Counts from 0 in the first SESSION cycle; expiry is evaluated at count TIMEOUT_CYC.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= expire;
            if (state_q == SESSION)
                timer_q <= timer_q + TMR_W'(1);
            else
                timer_q <= '0;
        end
    end
`else
    assign timer_done = 1'b0;
    assign timeout    = 1'b0;
`endif

    assign bus.req_ready  = (state_q == IDLE);
    assign session_active = (state_q == SESSION);
    assign all_voted      = (voted_count == NUM_IDS_C);

    logic unused_ok;
    assign unused_ok = do_abort;
endmodule

// File: tb/tb_voter_auth.sv
// tb/tb_voter_auth.sv - directed self-checking bench for voter_auth
module tb_voter_auth;
    localparam int ID_W    = 6;
    localparam int NUM_IDS = 40;
    localparam int CNT_W   = $clog2(NUM_IDS + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             session_active;
    logic [ID_W-1:0]  session_id;
    logic [CNT_W-1:0] voted_count;
    logic             all_voted;
    logic             timeout;

    int checks   = 0;
    int failures = 0;

    voter_auth_if #(.ID_W(ID_W)) bus ();

    voter_auth #(.ID_W(ID_W), .NUM_IDS(NUM_IDS), .TIMEOUT_CYC(10)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus.slave),
        .session_active (session_active),
        .session_id     (session_id),
        .voted_count    (voted_count),
        .all_voted      (all_voted),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input int id);
        logic [31:0] idv;
        idv           = id;
        bus.req_valid = 1'b1;
        bus.req_id    = idv[ID_W-1:0];
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic pulse_commit(input logic with_abort);
        bus.commit = 1'b1;
        bus.abort  = with_abort;
        tick();
        bus.commit = 1'b0;
        bus.abort  = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_id    = '0;
        bus.commit    = 1'b0;
        bus.abort     = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_code", bus.resp_code, 0);
        chk("rst_session", session_active, 0);
        chk("rst_session_id", session_id, 0);
        chk("rst_count", voted_count, 0);
        chk("rst_all_voted", all_voted, 0);
        chk("rst_timeout", timeout, 0);

        request(5);
        chk("id5_resp_valid", bus.resp_valid, 1);
        chk("id5_code", bus.resp_code, 2'b00);
        chk("id5_session", session_active, 1);
        chk("id5_session_id", session_id, 5);
        chk("id5_ready_low", bus.req_ready, 0);
        request(9);
        chk("id5_strobe_one_cycle", bus.resp_valid, 0);
        tick();
        chk("busy_req_ignored", bus.resp_valid, 0);
        chk("busy_session_id", session_id, 5);
        pulse_commit(1'b0);
        chk("id5_commit_idle", session_active, 0);
        chk("id5_commit_count", voted_count, 1);
        chk("idle_holds_id", session_id, 5);

        request(5);
        chk("id5_again_code", bus.resp_code, 2'b01);
        chk("id5_again_idle", session_active, 0);
        tick();

        request(45);
        chk("id45_code", bus.resp_code, 2'b10);
        chk("id45_idle", session_active, 0);
        request(39);
        chk("id39_code", bus.resp_code, 2'b00);
        chk("id39_session", session_active, 1);
        pulse_abort();

        request(7);
        chk("id7_code", bus.resp_code, 2'b00);
        pulse_commit(1'b1);
        chk("id7_both_count", voted_count, 2);
        chk("id7_both_idle", session_active, 0);
        request(7);
        chk("id7_flag_set", bus.resp_code, 2'b01);

        request(8);
        chk("id8_code", bus.resp_code, 2'b00);
        pulse_abort();
        chk("id8_abort_count", voted_count, 2);
        chk("id8_abort_idle", session_active, 0);
        request(8);
        chk("id8_regrant", bus.resp_code, 2'b00);
        pulse_abort();

        pulse_commit(1'b0);
        chk("idle_commit_ignored", voted_count, 2);

        for (int i = 0; i < NUM_IDS; i++) begin
            request(i);
            chk($sformatf("fill_code_%0d", i), bus.resp_code, (i == 5 || i == 7) ? 2'b01 : 2'b00);
            if (session_active)
                pulse_commit(1'b0);
        end
        chk("fill_count", voted_count, 40);
        chk("fill_all_voted", all_voted, 1);
        request(0);
        chk("full_refused", bus.resp_code, 2'b01);
        chk("full_count_held", voted_count, 40);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        request(10);
        chk("post_rst_id10", bus.resp_code, 2'b00);
        reset      = 1'b1;
        bus.commit = 1'b1;
        tick();
        reset      = 1'b0;
        bus.commit = 1'b0;
        chk("mid_rst_session", session_active, 0);
        chk("mid_rst_count", voted_count, 0);
        chk("mid_rst_all_voted", all_voted, 0);
        request(10);
        chk("mid_rst_id10_clear", bus.resp_code, 2'b00);
        pulse_abort();
        request(5);
        chk("mid_rst_id5_clear", bus.resp_code, 2'b00);
        pulse_abort();

        request(3);
        chk("id3_code", bus.resp_code, 2'b00);
`ifdef IDCHK_TIMEOUT_EN
        for (int c = 0; c < 10; c++)
            tick();
        chk("to_before_session", session_active, 1);
        chk("to_before_pulse", timeout, 0);
        tick();
        chk("to_pulse", timeout, 1);
        chk("to_idle", session_active, 0);
        chk("to_count", voted_count, 0);
        tick();
        chk("to_pulse_one_cycle", timeout, 0);
        request(3);
        chk("to_id3_regrant", bus.resp_code, 2'b00);
        pulse_abort();
`else
        for (int c = 0; c < 20; c++)
            tick();
        chk("no_to_session", session_active, 1);
        chk("no_to_pulse", timeout, 0);
        pulse_abort();
        chk("no_to_abort_idle", session_active, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
